// File: rtl/rr_lane_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-input/single-output
// resource among NUM_REQ requester lanes, one transaction at a time.
module rr_lane_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RES_LAT = 1,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        res_valid,
  output logic [DATA_W-1:0]           res_a,
  input  logic [DATA_W-1:0]           res_y,
  output logic                        busy,
  output logic [ID_W-1:0]             grant_id
);

  localparam int unsigned CNT_W = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 res_valid_q, res_valid_d;
  logic [DATA_W-1:0]    res_a_q, res_a_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 busy_q, busy_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;

  logic                 any_req;
  logic                 found_hi, found_lo;
  logic [ID_W-1:0]      hi_id, lo_id, win_id;
  logic [DATA_W-1:0]    hi_data, lo_data, win_data;

  assign any_req = |req_valid;

  // Winner: lowest requesting lane above last_grant, else lowest requesting lane (wrap).
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    hi_data  = '0;
    lo_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        if (!found_hi && (ID_W'(i) > last_grant_q)) begin
          found_hi = 1'b1;
          hi_id    = ID_W'(i);
          hi_data  = req_data[i*DATA_W +: DATA_W];
        end
        if (!found_lo) begin
          found_lo = 1'b1;
          lo_id    = ID_W'(i);
          lo_data  = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
    win_id   = found_hi ? hi_id   : lo_id;
    win_data = found_hi ? hi_data : lo_data;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    res_valid_d  = 1'b0;
    res_a_d      = res_a_q;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    req_ready    = '0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready   = NUM_REQ'(1) << win_id;
          res_a_d     = win_data;
          grant_id_d  = win_id;
          res_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(RES_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d  = res_y;
          rsp_valid_d = NUM_REQ'(1) << grant_id_q;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        last_grant_d = grant_id_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      res_valid_q  <= 1'b0;
      res_a_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
      grant_id_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      res_valid_q  <= res_valid_d;
      res_a_q      <= res_a_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      busy_q       <= busy_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign res_valid = res_valid_q;
  assign res_a     = res_a_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_rr_lane_arbiter.sv
// Bench for rr_lane_arbiter: two instances (RES_LAT=1 and RES_LAT=3) driven by
// directed scenarios and a randomized run checked against a transaction model.
module tb_rr_lane_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int L1 = 1;
  localparam int L3 = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;

  logic [N-1:0] rdy1, rspv1, rdy3, rspv3;
  logic [W-1:0] rspd1, resa1, resy1, rspd3, resa3, resy3;
  logic         resv1, busy1, resv3, busy3;
  logic [1:0]   gid1, gid3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_lane_arbiter #(.NUM_REQ(N), .DATA_W(W), .RES_LAT(L1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy1), .rsp_valid(rspv1), .rsp_data(rspd1), .res_valid(resv1),
    .res_a(resa1), .res_y(resy1), .busy(busy1), .grant_id(gid1));

  rr_lane_arbiter #(.NUM_REQ(N), .DATA_W(W), .RES_LAT(L3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy3), .rsp_valid(rspv3), .rsp_data(rspd3), .res_valid(resv3),
    .res_a(resa3), .res_y(resy3), .busy(busy3), .grant_id(gid3));

  // Shared resource model: y = ~a valid exactly RES_LAT cycles after res_valid, garbage otherwise.
  logic [W:0]   p1 [L1];
  logic [W:0]   p3 [L3];
  logic [W-1:0] garb;
  always @(posedge clk) begin
    garb  <= W'($urandom);
    p1[0] <= {resv1, ~resa1};
    for (int i = L3 - 1; i > 0; i--) p3[i] <= p3[i-1];
    p3[0] <= {resv3, ~resa3};
  end
  assign resy1 = (p1[L1-1][W] === 1'b1) ? p1[L1-1][W-1:0] : garb;
  assign resy3 = (p3[L3-1][W] === 1'b1) ? p3[L3-1][W-1:0] : garb;

  logic [N-1:0] o_rdy [2];
  logic [N-1:0] o_rspv[2];
  logic [W-1:0] o_rspd[2];
  logic [W-1:0] o_resa[2];
  logic         o_resv[2];
  logic         o_busy[2];
  logic [1:0]   o_gid [2];
  assign o_rdy[0] = rdy1;   assign o_rdy[1] = rdy3;
  assign o_rspv[0] = rspv1; assign o_rspv[1] = rspv3;
  assign o_rspd[0] = rspd1; assign o_rspd[1] = rspd3;
  assign o_resa[0] = resa1; assign o_resa[1] = resa3;
  assign o_resv[0] = resv1; assign o_resv[1] = resv3;
  assign o_busy[0] = busy1; assign o_busy[1] = busy3;
  assign o_gid[0] = gid1;   assign o_gid[1] = gid3;

  task automatic do_reset();
    req_valid = '0;
    req_data  = '0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [27:0] v1, v3;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    v1 = {rdy1, rspv1, rspd1, resv1, resa1, busy1, gid1};
    v3 = {rdy3, rspv3, rspd3, resv3, resa3, busy3, gid3};
    n_tests++;
    if (v1 !== '0 || v3 !== '0) begin
      n_fail++; $display("FAIL reset_state: got %h/%h exp 0/0", v1, v3);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      v1 = {rdy1, rspv1, rspd1, resv1, resa1, busy1, gid1};
      v3 = {rdy3, rspv3, rspd3, resv3, resa3, busy3, gid3};
      n_tests++;
      if (v1 !== '0 || v3 !== '0) begin
        n_fail++; $display("FAIL reset_idle c%0d: got %h/%h exp 0/0", c, v1, v3);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0100;
    req_data  = {8'h11, 8'hA5, 8'h22, 8'h33};
    #1;
    n_tests++;
    if (rdy1 !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b exp 0100", rdy1); end
    @(negedge clk);
    req_valid = '0;
    req_data  = '1;
    #1;
    n_tests++;
    if ({resv1, resa1, busy1, gid1, rdy1} !== {1'b1, 8'hA5, 1'b1, 2'd2, 4'b0000}) begin
      n_fail++; $display("FAIL single_issue: got resv=%b a=%h busy=%b gid=%0d rdy=%b exp 1 a5 1 2 0000",
                         resv1, resa1, busy1, gid1, rdy1);
    end
    @(negedge clk); #1;
    n_tests++;
    if ({resv1, busy1, rspv1, resa1} !== {1'b0, 1'b1, 4'b0000, 8'hA5}) begin
      n_fail++; $display("FAIL single_wait: got resv=%b busy=%b rspv=%b a=%h exp 0 1 0000 a5",
                         resv1, busy1, rspv1, resa1);
    end
    @(negedge clk); #1;
    n_tests++;
    if ({rspv1, rspd1, busy1} !== {4'b0100, 8'h5A, 1'b1}) begin
      n_fail++; $display("FAIL single_resp: got rspv=%b d=%h busy=%b exp 0100 5a 1", rspv1, rspd1, busy1);
    end
    @(negedge clk); #1;
    n_tests++;
    if ({rspv1, rspd1, busy1} !== {4'b0000, 8'h5A, 1'b0}) begin
      n_fail++; $display("FAIL single_hold: got rspv=%b d=%h busy=%b exp 0000 5a 0", rspv1, rspd1, busy1);
    end
  endtask

  task automatic test_all_lanes();
    logic [W-1:0] ops [N];
    int           ln;
    do_reset();
    for (int i = 0; i < N; i++) ops[i] = W'($urandom);
    @(negedge clk);
    req_valid = 4'b1111;
    req_data  = {ops[3], ops[2], ops[1], ops[0]};
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      ln = (c / 4) % N;
      n_tests++;
      if (rdy1 !== ((c % 4 == 0) ? 4'(1 << ln) : 4'b0000)) begin
        n_fail++; $display("FAIL all_lanes_ready c%0d: got %b exp lane %0d", c, rdy1, ln);
      end
      if (c % 4 == 3) begin
        n_tests++;
        if (rspv1 !== 4'(1 << ln) || rspd1 !== ~ops[ln]) begin
          n_fail++; $display("FAIL all_lanes_resp c%0d: got %b/%h exp %b/%h", c, rspv1, rspd1,
                             4'(1 << ln), ~ops[ln]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    req_valid = 4'b1000;
    req_data  = $urandom;
    #1;
    n_tests++;
    if (rdy1 !== 4'b1000) begin n_fail++; $display("FAIL wrap_first: got %b exp 1000", rdy1); end
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    req_valid = 4'b1001;
    #1;
    n_tests++;
    if (rdy1 !== 4'b0001) begin n_fail++; $display("FAIL wrap_lane0: got %b exp 0001", rdy1); end
    repeat (4) @(negedge clk);
    #1;
    n_tests++;
    if (rdy1 !== 4'b1000) begin n_fail++; $display("FAIL wrap_lane3: got %b exp 1000", rdy1); end
  endtask

  task automatic test_lat3();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0010;
    req_data  = {8'h01, 8'h02, 8'h3C, 8'h04};
    #1;
    n_tests++;
    if (rdy3 !== 4'b0010) begin n_fail++; $display("FAIL lat3_ready: got %b exp 0010", rdy3); end
    @(negedge clk);
    req_valid = '0;
    req_data  = '1;
    #1;
    n_tests++;
    if (resv3 !== 1'b1 || resa3 !== 8'h3C) begin
      n_fail++; $display("FAIL lat3_issue: got %b/%h exp 1/3c", resv3, resa3);
    end
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk); #1;
      n_tests++;
      if ({resv3, rspv3, busy3} !== {1'b0, 4'b0000, 1'b1}) begin
        n_fail++; $display("FAIL lat3_wait c%0d: got resv=%b rspv=%b busy=%b exp 0 0000 1",
                           c, resv3, rspv3, busy3);
      end
    end
    @(negedge clk); #1;
    n_tests++;
    if (rspv3 !== 4'b0010 || rspd3 !== 8'hC3) begin
      n_fail++; $display("FAIL lat3_resp: got %b/%h exp 0010/c3", rspv3, rspd3);
    end
    @(negedge clk); #1;
    n_tests++;
    if (busy3 !== 1'b0 || rspv3 !== 4'b0000) begin
      n_fail++; $display("FAIL lat3_done: got busy=%b rspv=%b exp 0 0000", busy3, rspv3);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0100;
    req_data  = {8'h11, 8'hA5, 8'h22, 8'h33};
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({resv1, resa1, busy1, gid1, resv3, resa3, busy3, gid3} !== '0) begin
      n_fail++; $display("FAIL reset_mid_async: got a=%h/%h busy=%b/%b gid=%0d/%0d exp all 0",
                         resa1, resa3, busy1, busy3, gid1, gid3);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      n_tests++;
      if (rspv1 !== '0 || rspv3 !== '0 || busy1 !== 1'b0 || busy3 !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid_quiet c%0d: got rspv=%b/%b busy=%b/%b exp 0", c,
                           rspv1, rspv3, busy1, busy3);
      end
    end
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    n_tests++;
    if (rdy1 !== 4'b0001 || rdy3 !== 4'b0001) begin
      n_fail++; $display("FAIL reset_mid_prio: got %b/%b exp 0001/0001", rdy1, rdy3);
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_random(input int ncyc);
    int           last [2];
    int           free_at [2];
    int           acc_c [2];
    int           lane [2];
    int           lat [2];
    bit           have [2];
    logic [W-1:0] opd [2];
    logic [W-1:0] rspd_e [2];
    logic [1:0]   gid_e [2];
    logic [N-1:0] e_rdy, e_rspv;
    logic [W-1:0] e_resa;
    logic         e_resv, e_busy;
    int           win, idx;
    do_reset();
    lat[0] = L1;
    lat[1] = L3;
    for (int d = 0; d < 2; d++) begin
      last[d] = N - 1; free_at[d] = 0; acc_c[d] = 0; lane[d] = 0;
      have[d] = 1'b0; opd[d] = '0; rspd_e[d] = '0; gid_e[d] = '0;
    end
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      req_data  = {$urandom};
      #1;
      for (int d = 0; d < 2; d++) begin
        win = -1;
        if (c >= free_at[d]) begin
          for (int k = 1; k <= N; k++) begin
            idx = (last[d] + k) % N;
            if (win < 0 && req_valid[idx]) win = idx;
          end
        end
        e_rdy  = (win >= 0) ? 4'(1 << win) : 4'b0000;
        e_resv = have[d] && (c == acc_c[d] + 1);
        e_busy = have[d] && (c >= acc_c[d] + 1) && (c <= acc_c[d] + lat[d] + 2);
        e_rspv = (have[d] && (c == acc_c[d] + lat[d] + 2)) ? 4'(1 << lane[d]) : 4'b0000;
        if (e_rspv != 0) rspd_e[d] = ~opd[d];
        e_resa = opd[d];
        n_tests++;
        if (o_rdy[d] !== e_rdy) begin
          n_fail++; $display("FAIL rand_ready d%0d c%0d: got %b exp %b", d, c, o_rdy[d], e_rdy);
        end
        n_tests++;
        if (o_resv[d] !== e_resv || (e_resv && o_resa[d] !== e_resa)) begin
          n_fail++; $display("FAIL rand_issue d%0d c%0d: got %b/%h exp %b/%h", d, c,
                             o_resv[d], o_resa[d], e_resv, e_resa);
        end
        n_tests++;
        if (o_busy[d] !== e_busy || o_gid[d] !== gid_e[d]) begin
          n_fail++; $display("FAIL rand_busy d%0d c%0d: got %b/%0d exp %b/%0d", d, c,
                             o_busy[d], o_gid[d], e_busy, gid_e[d]);
        end
        n_tests++;
        if (o_rspv[d] !== e_rspv || o_rspd[d] !== rspd_e[d]) begin
          n_fail++; $display("FAIL rand_resp d%0d c%0d: got %b/%h exp %b/%h", d, c,
                             o_rspv[d], o_rspd[d], e_rspv, rspd_e[d]);
        end
        if (win >= 0) begin
          have[d]    = 1'b1;
          acc_c[d]   = c;
          lane[d]    = win;
          opd[d]     = W'(req_data >> (win * W));
          free_at[d] = c + lat[d] + 3;
          last[d]    = win;
          gid_e[d]   = 2'(win);
        end
      end
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_lanes();
    test_wrap();
    test_lat3();
    test_reset_mid();
    test_random(600);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
